// File: rtl/arb_pkg.sv
// arb_pkg: output-stage state type and width helpers shared by the arbiter request frontend
package arb_pkg;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/arb_req_fifo.sv
// arb_req_fifo: single-clock per-channel FIFO, power-of-two depth with naturally wrapping pointers
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    localparam int CNT_W = cnt_w(FIFO_DEPTH);
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push, w_pop;
    assign full   = r_count == CNT_W'(FIFO_DEPTH);
    assign empty  = r_count == '0;
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end
endmodule

// File: rtl/arb_req_frontend.sv
// arb_req_frontend: per-channel FIFOs driving arbiter req, one-hot gnt selects head onto shared valid/ready output; ARB_REQ_FRONTEND_CHK_EN adds sticky gnt_err
module arb_req_frontend
    import arb_pkg::*;
#(
    parameter int NUM_REQ    = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         in_valid,
    output logic [NUM_REQ-1:0]         in_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  in_data,
    output logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         gnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
`ifdef ARB_REQ_FRONTEND_CHK_EN
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       gnt_err
`else
    output logic [$clog2(NUM_REQ)-1:0] out_id
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);
    out_state_t          r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  w_full, w_empty, w_acc, w_pop;
    logic [DATA_W-1:0]   w_head [NUM_REQ];
    logic                w_can_load, w_load;
    logic [ID_W-1:0]     w_id;
    logic [DATA_W-1:0]   r_out_data;
    logic [ID_W-1:0]     r_out_id;
    assign w_can_load = (r_state == OUT_EMPTY) | out_ready;
    assign req        = ~w_empty & {NUM_REQ{w_can_load}};
    assign in_ready   = ~w_full & {NUM_REQ{~rst}};
    assign w_acc      = gnt & req;
    // Isolate the lowest accepted grant bit so a malformed gnt pops at most one FIFO
    assign w_pop      = w_acc & (~w_acc + 1'b1);
    assign w_load     = |w_acc;
    always_comb begin
        w_id = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) w_id = w_acc[k] ? ID_W'(k) : w_id;
    end
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
        arb_req_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (in_valid[i] & in_ready[i]),
            .pop  (w_pop[i]),
            .din  (in_data[i*DATA_W +: DATA_W]),
            .dout (w_head[i]),
            .full (w_full[i]),
            .empty(w_empty[i])
        );
    end
    always_comb begin
        w_state_nxt = w_load ? OUT_FULL : (out_ready ? OUT_EMPTY : r_state);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= OUT_EMPTY;
        else r_state <= w_state_nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_id   <= '0;
        end else if (w_load) begin
            r_out_data <= w_head[w_id];
            r_out_id   <= w_id;
        end
    end
    assign out_valid = r_state == OUT_FULL;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
`ifdef ARB_REQ_FRONTEND_CHK_EN
    logic r_gnt_err, w_illegal;
    assign w_illegal = (|(gnt & ~req)) | (|(gnt & (gnt - 1'b1)));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_gnt_err <= 1'b0;
        else if (w_illegal) r_gnt_err <= 1'b1;
    end
    assign gnt_err = r_gnt_err;
`endif
endmodule

// File: tb/tb_arb_req_frontend.sv
// tb_arb_req_frontend: vector table, directed corner sequences and random traffic against a queue-based model
module tb_arb_req_frontend;
    localparam int N = 10;
    localparam int W = 32;
    localparam int D = 4;
    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid, in_ready, req, gnt;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_data;
    logic [3:0]     out_id;
`ifdef ARB_REQ_FRONTEND_CHK_EN
    logic           gnt_err;
`endif
    always #5 clk = ~clk;
    arb_req_frontend #(.NUM_REQ(N), .DATA_W(W), .FIFO_DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .req      (req),
        .gnt      (gnt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef ARB_REQ_FRONTEND_CHK_EN
        .out_id   (out_id),
        .gnt_err  (gnt_err)
`else
        .out_id   (out_id)
`endif
    );
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] q [N][$];
    logic         m_ov;
    logic [W-1:0] m_od;
    logic [3:0]   m_oid;
    logic         m_err;
    typedef struct {
        logic [N-1:0] iv;
        logic [W-1:0] d;
        logic         ordy;
        logic [N-1:0] g;
        logic [N-1:0] e_req;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic [3:0]   e_id;
    } vec_t;
    vec_t tbl [10];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [N-1:0] m_req(input logic ordy);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = (q[i].size() > 0) && (!m_ov || ordy);
        return r;
    endfunction
    function automatic logic [N-1:0] m_rdy();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = q[i].size() < D;
        return r;
    endfunction
    function automatic logic [N*W-1:0] put(input int ch, input logic [W-1:0] v);
        logic [N*W-1:0] r = '0;
        r[ch*W +: W] = v;
        return r;
    endfunction
    function automatic logic [N-1:0] pick_one(input logic [N-1:0] v);
        int s = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++)
            if (v[(s + k) % N]) return N'(1) << ((s + k) % N);
        return '0;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        m_ov = 1'b0; m_od = '0; m_oid = '0; m_err = 1'b0;
    endtask
    task automatic cycle(input logic [N-1:0] iv, input logic [N*W-1:0] d, input logic ordy,
                         input logic [N-1:0] g, output logic [N-1:0] s_req, output logic [N-1:0] s_rdy);
        logic [N-1:0] e_req, e_rdy;
        int acc = -1;
        in_valid = iv; in_data = d; out_ready = ordy; gnt = g;
        e_req = m_req(ordy);
        e_rdy = m_rdy();
        #1;
        s_req = req; s_rdy = in_ready;
        chk("req", req, e_req);
        chk("in_ready", in_ready, e_rdy);
        for (int i = 0; i < N; i++) if (g[i] && e_req[i]) begin acc = i; break; end
        if ((g & ~e_req) != '0 || $countones(g) > 1) m_err = 1'b1;
        @(posedge clk);
        if (acc >= 0) begin
            m_od = q[acc].pop_front(); m_oid = 4'(acc); m_ov = 1'b1;
        end else if (ordy) m_ov = 1'b0;
        for (int i = 0; i < N; i++) if (iv[i] && e_rdy[i]) q[i].push_back(d[i*W +: W]);
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_id", out_id, m_oid);
`ifdef ARB_REQ_FRONTEND_CHK_EN
        chk("gnt_err", gnt_err, m_err);
`endif
    endtask
    initial begin
        logic [N-1:0] sr, sy, g, e;
        logic [N*W-1:0] d;
        logic [W-1:0] seq [$];
        int cnt [N];
        int nxt [N];
        int total, rr_last;
        tbl[0] = '{10'h008, 32'hA5A5_0001, 1'b1, 10'h000, 10'h000, 1'b0, 32'h0,         4'd0};
        tbl[1] = '{10'h000, 32'h0,         1'b1, 10'h008, 10'h008, 1'b1, 32'hA5A5_0001, 4'd3};
        tbl[2] = '{10'h000, 32'h0,         1'b1, 10'h000, 10'h000, 1'b0, 32'hA5A5_0001, 4'd3};
        tbl[3] = '{10'h001, 32'h11,        1'b0, 10'h000, 10'h000, 1'b0, 32'hA5A5_0001, 4'd3};
        tbl[4] = '{10'h000, 32'h0,         1'b0, 10'h010, 10'h001, 1'b0, 32'hA5A5_0001, 4'd3};
        tbl[5] = '{10'h000, 32'h0,         1'b0, 10'h011, 10'h001, 1'b1, 32'h11,         4'd0};
        tbl[6] = '{10'h002, 32'h22,        1'b0, 10'h000, 10'h000, 1'b1, 32'h11,         4'd0};
        tbl[7] = '{10'h000, 32'h0,         1'b0, 10'h002, 10'h000, 1'b1, 32'h11,         4'd0};
        tbl[8] = '{10'h000, 32'h0,         1'b1, 10'h002, 10'h002, 1'b1, 32'h22,         4'd1};
        tbl[9] = '{10'h000, 32'h0,         1'b1, 10'h000, 10'h000, 1'b0, 32'h22,         4'd1};
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0; gnt = '0;
        model_reset();
        #2;
        chk("rst_in_ready", in_ready, 10'h000);
        chk("rst_req", req, 10'h000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_id", out_id, 4'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rel_in_ready", in_ready, 10'h3FF);
        for (int k = 0; k < 10; k++) begin
            cycle(tbl[k].iv, {N{tbl[k].d}}, tbl[k].ordy, tbl[k].g, sr, sy);
            chk($sformatf("tbl%0d_req", k), sr, tbl[k].e_req);
            chk($sformatf("tbl%0d_ov", k), out_valid, tbl[k].e_ov);
            chk($sformatf("tbl%0d_od", k), out_data, tbl[k].e_od);
            chk($sformatf("tbl%0d_id", k), out_id, tbl[k].e_id);
        end
`ifdef ARB_REQ_FRONTEND_CHK_EN
        chk("gnt_err_sticky", gnt_err, 1'b1);
`endif
        cycle(10'h084, put(2, 32'h200) | put(7, 32'h700), 1'b1, 10'h000, sr, sy);
        cycle(10'h004, put(2, 32'h201), 1'b1, 10'h080, sr, sy);
        cycle(10'h004, put(2, 32'h202), 1'b0, 10'h000, sr, sy);
        chk("pre_rst_ov", out_valid, 1'b1);
        rst = 1'b1; in_valid = '0;
        #1;
        chk("mid_rst_req", req, 10'h000);
        chk("mid_rst_ov", out_valid, 1'b0);
        chk("mid_rst_rdy", in_ready, 10'h000);
        chk("mid_rst_od", out_data, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("mid_rel_rdy", in_ready, 10'h3FF);
        cycle(10'h000, '0, 1'b1, 10'h004, sr, sy);
        chk("ch2_empty_req", sr, 10'h000);
        cycle(10'h003, put(0, 32'h1000) | put(1, 32'h1001), 1'b1, 10'h000, sr, sy);
        cycle(10'h003, put(0, 32'h1002) | put(1, 32'h1003), 1'b1, 10'h001, sr, sy);
        for (int k = 0; k < 5; k++) begin
            cycle(10'h000, '0, 1'b0, 10'h003, sr, sy);
            chk("bp_req", sr, 10'h000);
            chk("bp_hold", out_data, 32'h1000);
        end
        for (int k = 0; k < 3; k++) begin
            e = m_req(1'b1);
            cycle(10'h000, '0, 1'b1, e & (~e + 1'b1), sr, sy);
            chk("b2b_ov", out_valid, 1'b1);
        end
        cycle(10'h000, '0, 1'b1, 10'h000, sr, sy);
        for (int v = 1; v <= 4; v++) cycle(10'h020, put(5, 32'(v)), 1'b1, 10'h000, sr, sy);
        cycle(10'h020, put(5, 32'd5), 1'b1, 10'h000, sr, sy);
        chk("full_rdy5", sy[5], 1'b0);
        cycle(10'h020, put(5, 32'd5), 1'b1, 10'h020, sr, sy);
        chk("full_nobypass", sy[5], 1'b0);
        if (out_valid) seq.push_back(out_data);
        cycle(10'h020, put(5, 32'd5), 1'b1, 10'h020, sr, sy);
        chk("full_rdy5_back", sy[5], 1'b1);
        if (out_valid) seq.push_back(out_data);
        for (int k = 0; k < 8; k++) begin
            cycle(10'h000, '0, 1'b1, m_req(1'b1) & 10'h020, sr, sy);
            if (out_valid) seq.push_back(out_data);
        end
        chk("order_len", seq.size(), 5);
        for (int k = 0; k < 5 && k < seq.size(); k++) chk("order_val", seq[k], 32'(k + 1));
        rst = 1'b1; #1; model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) d[i*W +: W] = 32'((i << 8) | r);
            cycle(10'h3FF, d, 1'b1, 10'h000, sr, sy);
        end
        for (int i = 0; i < N; i++) begin cnt[i] = 0; nxt[i] = 0; end
        total = 0; rr_last = N - 1;
        for (int t = 0; t < 40 && total < 30; t++) begin
            e = m_req(1'b1); g = '0;
            for (int k = 1; k <= N; k++)
                if (e[(rr_last + k) % N]) begin rr_last = (rr_last + k) % N; g[rr_last] = 1'b1; break; end
            cycle(10'h000, '0, 1'b1, g, sr, sy);
            if (out_valid && out_id < N) begin
                chk("rr_order", out_data, 32'((int'(out_id) << 8) | nxt[out_id]));
                nxt[out_id]++; cnt[out_id]++; total++;
            end
        end
        chk("rr_total", total, 30);
        for (int i = 0; i < N; i++) chk($sformatf("rr_cnt%0d", i), cnt[i], 3);
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
            case ($urandom_range(0, 9))
                7: g = N'($urandom);
                8, 9: g = '0;
                default: g = pick_one(m_req(1'b1));
            endcase
            e = N'($urandom);
            if ($urandom_range(0, 3) != 0) cycle(e, d, 1'b1, g, sr, sy);
            else cycle(e, d, 1'b0, pick_one(m_req(1'b0)) | (g & 10'h000), sr, sy);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
